// File: rtl/alu_exec_if.sv
// Request/response bundle for the ALU execution unit: requester side is master,
// the unit itself is slave.
interface alu_exec_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 10,
    parameter int RD_WIDTH   = 5
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [OP_WIDTH-1:0]   alu_operation;
    logic [DATA_WIDTH-1:0] alu_mask;
    logic [DATA_WIDTH-1:0] src1;
    logic [DATA_WIDTH-1:0] src2;
    logic [RD_WIDTH-1:0]   rd_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic [RD_WIDTH-1:0]   rd_out;
    logic                  op_err;

    modport master (
        output flush, in_valid, alu_operation, alu_mask, src1, src2, rd_in, out_ready,
        input  in_ready, out_valid, result, rd_out, op_err
    );

    modport slave (
        input  flush, in_valid, alu_operation, alu_mask, src1, src2, rd_in, out_ready,
        output in_ready, out_valid, result, rd_out, op_err
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Single-issue ALU with one-hot op select; shifts run serially one bit per cycle,
// everything else completes in one cycle into a registered, masked result.
module alu_exec_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 10,
    parameter int RD_WIDTH   = 5
) (
    input logic       clk,
    input logic       rst,
    alu_exec_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_kind_t;

    state_t                state;
    shift_kind_t           shift_kind;
    logic [DATA_WIDTH-1:0] work;
    logic [DATA_WIDTH-1:0] mask_q;
    logic [RD_WIDTH-1:0]   rd_q;
    logic [4:0]            count;

    logic                  accept;
    logic                  op_onehot;
    logic                  is_shift;
    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] alu_value;
    logic [DATA_WIDTH-1:0] shift_next;

    assign bus.in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign shamt        = bus.src2[4:0];
    assign is_shift     = |bus.alu_operation[5:3];
    assign op_onehot    = (bus.alu_operation != '0) &&
                          ((bus.alu_operation & (bus.alu_operation - OP_WIDTH'(1))) == '0);

    // Single-cycle datapath; a shift only lands here when its amount is zero.
    always_comb begin
        alu_value = '0;
        if (bus.alu_operation[0])      alu_value = bus.src1 + bus.src2;
        else if (bus.alu_operation[1]) alu_value = bus.src1 - bus.src2;
        else if (bus.alu_operation[2]) alu_value = bus.src1 ^ bus.src2;
        else if (is_shift)             alu_value = bus.src1;
        else if (bus.alu_operation[6]) alu_value = bus.src1 | bus.src2;
        else if (bus.alu_operation[7]) alu_value = bus.src1 & bus.src2;
        else if (bus.alu_operation[8])
            alu_value = {{(DATA_WIDTH-1){1'b0}}, ($signed(bus.src1) < $signed(bus.src2))};
        else if (bus.alu_operation[9])
            alu_value = {{(DATA_WIDTH-1){1'b0}}, (bus.src1 < bus.src2)};
    end

    always_comb begin
        case (shift_kind)
            SH_LL:   shift_next = work << 1;
            SH_RL:   shift_next = work >> 1;
            default: shift_next = {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};
        endcase
    end

    // Flush outranks a same-cycle accept; a new accept in DONE replaces the old result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            shift_kind    <= SH_LL;
            work          <= '0;
            mask_q        <= '0;
            rd_q          <= '0;
            count         <= '0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.rd_out    <= '0;
            bus.op_err    <= 1'b0;
        end else if (bus.flush) begin
            state         <= IDLE;
            count         <= '0;
            bus.out_valid <= 1'b0;
            bus.op_err    <= 1'b0;
        end else if (accept) begin
            mask_q <= bus.alu_mask;
            rd_q   <= bus.rd_in;
            if (!op_onehot) begin
                bus.result    <= '0;
                bus.rd_out    <= bus.rd_in;
                bus.op_err    <= 1'b1;
                bus.out_valid <= 1'b1;
                state         <= DONE;
            end else if (is_shift && (shamt != 5'd0)) begin
                work          <= bus.src1;
                count         <= shamt;
                shift_kind    <= bus.alu_operation[3] ? SH_LL :
                                 bus.alu_operation[4] ? SH_RL : SH_RA;
                bus.op_err    <= 1'b0;
                bus.out_valid <= 1'b0;
                state         <= SHIFT;
            end else begin
                bus.result    <= alu_value & bus.alu_mask;
                bus.rd_out    <= bus.rd_in;
                bus.op_err    <= 1'b0;
                bus.out_valid <= 1'b1;
                state         <= DONE;
            end
        end else begin
            case (state)
                SHIFT: begin
                    work  <= shift_next;
                    count <= count - 5'd1;
                    if (count == 5'd1) begin
                        bus.result    <= shift_next & mask_q;
                        bus.rd_out    <= rd_q;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
